// File: rtl/fifo_bus_slave_pkg.sv
// Shared definitions for the FIFO bus slave: register offsets, STATUS and
// CTRL bit positions, FSM state encoding and read-data source selection.
package fifo_bus_slave_pkg;

  // Register offsets on s_addr
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_THRESH = 2'd3;

  // STATUS bit positions
  localparam int ST_UDF       = 9;
  localparam int ST_OVF       = 8;
  localparam int ST_FULL      = 7;
  localparam int ST_EMPTY     = 6;
  localparam int ST_COUNT_MSB = 5;

  // CTRL bit positions
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_FLUSH  = 1;

  // FSM state: reflects the last accepted DATA access
  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_NO_OP    = 3'd1,
    ST_WRITE    = 3'd2,
    ST_WR_ERROR = 3'd3,
    ST_READ     = 3'd4,
    ST_RD_ERROR = 3'd5
  } state_t;

  // Source of the next s_dout value
  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_FIFO   = 3'd1,
    SEL_ZERO   = 3'd2,
    SEL_STATUS = 3'd3,
    SEL_CTRL   = 3'd4,
    SEL_THRESH = 3'd5
  } dout_sel_t;

endpackage

// File: rtl/fifo_bus_slave_ns.sv
// Access decoder for the FIFO bus slave: from the current state and the bus
// access it derives the next FSM state, the read-data source and the
// one-cycle update strobes applied by the storage in the top level.
module fifo_bus_slave_ns
  import fifo_bus_slave_pkg::*;
(
  input  state_t       state,
  input  logic         s_sel,
  input  logic         s_wr,
  input  logic [1:0]   s_addr,
  input  logic         full,
  input  logic         empty,
  input  logic         flush_req,
  output state_t       next_state,
  output dout_sel_t    dout_sel,
  output logic         push,
  output logic         pop,
  output logic         ovf_set,
  output logic         udf_set,
  output logic         flush,
  output logic         ctrl_we,
  output logic         thresh_we
);

  // Decode the bus access; INIT and idle cycles do nothing and go to NO_OP
  always_comb begin
    next_state = ST_NO_OP;
    dout_sel   = SEL_HOLD;
    push       = 1'b0;
    pop        = 1'b0;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
    flush      = 1'b0;
    ctrl_we    = 1'b0;
    thresh_we  = 1'b0;
    if ((state == ST_INIT) || !s_sel) begin
      next_state = ST_NO_OP;
    end else begin
      case (s_addr)
        ADDR_DATA: begin
          if (s_wr) begin
            if (full) begin
              next_state = ST_WR_ERROR;
              ovf_set    = 1'b1;
            end else begin
              next_state = ST_WRITE;
              push       = 1'b1;
            end
          end else begin
            if (empty) begin
              next_state = ST_RD_ERROR;
              udf_set    = 1'b1;
              dout_sel   = SEL_ZERO;
            end else begin
              next_state = ST_READ;
              pop        = 1'b1;
              dout_sel   = SEL_FIFO;
            end
          end
        end
        ADDR_STATUS: begin
          // STATUS is read-only; a write is silently ignored
          if (s_wr) begin
            dout_sel = SEL_HOLD;
          end else begin
            dout_sel = SEL_STATUS;
          end
        end
        ADDR_CTRL: begin
          if (s_wr) begin
            ctrl_we = 1'b1;
            flush   = flush_req;
          end else begin
            dout_sel = SEL_CTRL;
          end
        end
        ADDR_THRESH: begin
          if (s_wr) begin
            thresh_we = 1'b1;
          end else begin
            dout_sel = SEL_THRESH;
          end
        end
        default: begin
          next_state = ST_NO_OP;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_bus_slave.sv
// FIFO bus slave: a DEPTH-entry FIFO behind a four-register bus window
// (DATA, STATUS, CTRL, THRESH) with sticky overflow/underflow flags and a
// registered read port. Defining FIFO_BUS_SLAVE_IRQ_EN adds the level
// interrupt output s_interrupt and the CTRL irq_en bit.
module fifo_bus_slave
  import fifo_bus_slave_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [1:0]        s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout
`ifdef FIFO_BUS_SLAVE_IRQ_EN
  ,
  output logic              s_interrupt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              ovf_r;
  logic              udf_r;
  logic [CW-1:0]     thresh_r;
  state_t            state_r;

  logic [AW-1:0]     wr_ptr_nxt_s;
  logic [AW-1:0]     rd_ptr_nxt_s;
  logic [CW-1:0]     count_nxt_s;
  logic              ovf_nxt_s;
  logic              udf_nxt_s;
  logic [CW-1:0]     thresh_nxt_s;
  logic [DATA_W-1:0] dout_nxt_s;
  logic [DATA_W-1:0] status_s;
  logic [DATA_W-1:0] ctrl_s;
  logic              full_s;
  logic              empty_s;

  state_t            next_state_s;
  dout_sel_t         dout_sel_s;
  logic              push_s;
  logic              pop_s;
  logic              ovf_set_s;
  logic              udf_set_s;
  logic              flush_s;
  logic              ctrl_we_s;
  logic              thresh_we_s;

`ifdef FIFO_BUS_SLAVE_IRQ_EN
  logic              irq_en_r;
  logic              irq_en_nxt_s;
  logic              irq_nxt_s;
`endif

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == '0);

  fifo_bus_slave_ns u_ns (
    .state      (state_r),
    .s_sel      (s_sel),
    .s_wr       (s_wr),
    .s_addr     (s_addr),
    .full       (full_s),
    .empty      (empty_s),
    .flush_req  (s_din[CTRL_FLUSH]),
    .next_state (next_state_s),
    .dout_sel   (dout_sel_s),
    .push       (push_s),
    .pop        (pop_s),
    .ovf_set    (ovf_set_s),
    .udf_set    (udf_set_s),
    .flush      (flush_s),
    .ctrl_we    (ctrl_we_s),
    .thresh_we  (thresh_we_s)
  );

  // Pointer, occupancy and sticky-flag updates; flush clears everything
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    ovf_nxt_s    = ovf_r | ovf_set_s;
    udf_nxt_s    = udf_r | udf_set_s;
    if (flush_s) begin
      wr_ptr_nxt_s = '0;
      rd_ptr_nxt_s = '0;
      count_nxt_s  = '0;
      ovf_nxt_s    = 1'b0;
      udf_nxt_s    = 1'b0;
    end else if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + AW'(1'b1);
      count_nxt_s  = count_r + CW'(1'b1);
    end else if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1'b1);
      count_nxt_s  = count_r - CW'(1'b1);
    end else begin
      count_nxt_s  = count_r;
    end
  end

  // Configuration register updates and the interrupt level they imply
  always_comb begin
    thresh_nxt_s = thresh_r;
    if (thresh_we_s) begin
      thresh_nxt_s = s_din[CW-1:0];
    end else begin
      thresh_nxt_s = thresh_r;
    end
`ifdef FIFO_BUS_SLAVE_IRQ_EN
    if (ctrl_we_s) begin
      irq_en_nxt_s = s_din[CTRL_IRQ_EN];
    end else begin
      irq_en_nxt_s = irq_en_r;
    end
    irq_nxt_s = irq_en_nxt_s &
                ((count_nxt_s >= thresh_nxt_s) | ovf_nxt_s | udf_nxt_s);
`endif
  end

  // Readable register images, zero-extended to the bus width
  always_comb begin
    status_s                 = '0;
    status_s[ST_COUNT_MSB:0] = 6'(count_r);
    status_s[ST_EMPTY]       = empty_s;
    status_s[ST_FULL]        = full_s;
    status_s[ST_OVF]         = ovf_r;
    status_s[ST_UDF]         = udf_r;
    ctrl_s                   = '0;
`ifdef FIFO_BUS_SLAVE_IRQ_EN
    ctrl_s[CTRL_IRQ_EN]      = irq_en_r;
`endif
  end

  // Read-data select: s_dout only changes on an accepted read
  always_comb begin
    case (dout_sel_s)
      SEL_HOLD:   dout_nxt_s = s_dout;
      SEL_FIFO:   dout_nxt_s = mem_r[rd_ptr_r];
      SEL_ZERO:   dout_nxt_s = '0;
      SEL_STATUS: dout_nxt_s = status_s;
      SEL_CTRL:   dout_nxt_s = ctrl_s;
      SEL_THRESH: dout_nxt_s = DATA_W'(thresh_r);
      default:    dout_nxt_s = s_dout;
    endcase
  end

  // Control state, pointers, flags and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_INIT;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      ovf_r       <= 1'b0;
      udf_r       <= 1'b0;
      thresh_r    <= CW'(DEPTH);
      s_dout      <= '0;
`ifdef FIFO_BUS_SLAVE_IRQ_EN
      irq_en_r    <= 1'b0;
      s_interrupt <= 1'b0;
`endif
    end else begin
      state_r     <= next_state_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      ovf_r       <= ovf_nxt_s;
      udf_r       <= udf_nxt_s;
      thresh_r    <= thresh_nxt_s;
      s_dout      <= dout_nxt_s;
`ifdef FIFO_BUS_SLAVE_IRQ_EN
      irq_en_r    <= irq_en_nxt_s;
      s_interrupt <= irq_nxt_s;
`endif
    end
  end

  // FIFO storage; contents are not cleared by reset or flush
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_r[wr_ptr_r] <= s_din;
    end
  end

endmodule

// File: tb/tb_fifo_bus_slave.sv
// Self-checking bench for fifo_bus_slave: directed scenarios followed by
// randomized bus traffic, all compared against a queue-based model.
module tb_fifo_bus_slave;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              s_sel;
  logic              s_wr;
  logic [1:0]        s_addr;
  logic [DATA_W-1:0] s_din;
  logic [DATA_W-1:0] s_dout;
`ifdef FIFO_BUS_SLAVE_IRQ_EN
  logic              s_interrupt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_q[$];
  logic        m_ovf, m_udf, m_irq_en, m_init, m_irq;
  logic [31:0] m_thresh;
  logic [31:0] m_dout;

  fifo_bus_slave #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .s_sel  (s_sel),
    .s_wr   (s_wr),
    .s_addr (s_addr),
    .s_din  (s_din),
    .s_dout (s_dout)
`ifdef FIFO_BUS_SLAVE_IRQ_EN
    ,
    .s_interrupt (s_interrupt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] v;
    v = 32'(m_q.size());
    if (m_q.size() == 0)     v = v | 32'h40;
    if (m_q.size() == DEPTH) v = v | 32'h80;
    if (m_ovf)               v = v | 32'h100;
    if (m_udf)               v = v | 32'h200;
    return v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_irq_en = 1'b0; m_init = 1'b1;
    m_thresh = 32'(DEPTH);
    m_dout = 32'h0;
  endtask

  task automatic model_edge(input logic sel, input logic wr, input logic [1:0] addr,
                            input logic [31:0] din);
    if (m_init) begin
      m_init = 1'b0;
    end else if (sel) begin
      case (addr)
        2'd0: begin
          if (wr) begin
            if (m_q.size() == DEPTH) m_ovf = 1'b1;
            else m_q.push_back(din);
          end else begin
            if (m_q.size() == 0) begin m_udf = 1'b1; m_dout = 32'h0; end
            else m_dout = m_q.pop_front();
          end
        end
        2'd1: if (!wr) m_dout = m_status();
        2'd2: begin
          if (wr) begin
`ifdef FIFO_BUS_SLAVE_IRQ_EN
            m_irq_en = din[0];
`endif
            if (din[1]) begin m_q.delete(); m_ovf = 1'b0; m_udf = 1'b0; end
          end else begin
            m_dout = {31'h0, m_irq_en};
          end
        end
        default: begin
          if (wr) m_thresh = din & 32'(2 * DEPTH - 1);
          else m_dout = m_thresh;
        end
      endcase
    end
  endtask

  // One clock cycle of bus activity, checked after the edge
  task automatic cyc(input logic sel, input logic wr, input logic [1:0] addr,
                     input logic [31:0] din);
    s_sel = sel; s_wr = wr; s_addr = addr; s_din = din;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(sel, wr, addr, din);
    m_irq = m_irq_en && ((32'(m_q.size()) >= m_thresh) || m_ovf || m_udf);
    #1;
    check_val("dout", s_dout, m_dout);
`ifdef FIFO_BUS_SLAVE_IRQ_EN
    check_val("irq", {31'h0, s_interrupt}, {31'h0, m_irq});
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0, 2'd0, 32'h0);
    reset = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1'b1, 1'b0, a, $urandom);
  endtask

  task automatic idle();
    cyc(1'b0, 1'($urandom), 2'($urandom), $urandom);
  endtask

  initial begin
    reset = 1'b1; s_sel = 1'b0; s_wr = 1'b0; s_addr = 2'd0; s_din = 32'h0;
    model_reset();
    do_reset();
    check_val("rst_dout", s_dout, 32'h0);
    // Access in the INIT cycle is ignored
    wr(2'd0, 32'h55);
    rd(2'd1);
    check_val("status_after_reset", s_dout, 32'h40);
    rd(2'd3);
    check_val("thresh_reset", s_dout, 32'(DEPTH));

    // In-order data
    for (int i = 0; i < 4; i++) wr(2'd0, 32'(10 + i));
    for (int i = 0; i < 4; i++) begin
      rd(2'd0);
      check_val("fifo_order", s_dout, 32'(10 + i));
    end
    idle(); idle();
    check_val("dout_hold", s_dout, 32'd13);
    rd(2'd1);
    check_val("status_empty", s_dout, 32'h40);

    // Overflow
    for (int i = 0; i < 9; i++) wr(2'd0, 32'(100 + i));
    rd(2'd1);
    check_val("status_ovf", s_dout, 32'h188);
    for (int i = 0; i < 8; i++) begin
      rd(2'd0);
      check_val("ovf_pop", s_dout, 32'(100 + i));
    end

    // Underflow and flush
    rd(2'd0);
    check_val("udf_dout", s_dout, 32'h0);
    rd(2'd1);
    check_val("status_udf", s_dout, 32'h340);
    wr(2'd2, 32'h2);
    rd(2'd1);
    check_val("status_flush", s_dout, 32'h40);
    rd(2'd2);
    check_val("ctrl_selfclr", s_dout, 32'h0);
    wr(2'd3, 32'hFF);
    rd(2'd3);
    check_val("thresh_mask", s_dout, 32'hF);

    // Threshold interrupt
    wr(2'd2, 32'h1);
    wr(2'd3, 32'h3);
    for (int i = 0; i < 3; i++) wr(2'd0, 32'(200 + i));
`ifdef FIFO_BUS_SLAVE_IRQ_EN
    check_val("irq_on", {31'h0, s_interrupt}, 32'h1);
`endif
    rd(2'd0);
    check_val("irq_pop_data", s_dout, 32'd200);
`ifdef FIFO_BUS_SLAVE_IRQ_EN
    check_val("irq_off", {31'h0, s_interrupt}, 32'h0);
`endif

    // Reset mid-operation
    for (int i = 0; i < 5; i++) wr(2'd0, 32'(300 + i));
    do_reset();
    check_val("midrst_dout", s_dout, 32'h0);
    idle();
    rd(2'd1);
    check_val("midrst_status", s_dout, 32'h40);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [1:0] a;
      logic [31:0] d;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
      end else begin
        a = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom);
        d = $urandom;
        if (a == 2'd2 && $urandom_range(0, 9) != 0) d[1] = 1'b0;
        cyc(r < 85, 1'($urandom), a, d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
